// File: rtl/move_exec_scheduler_pkg.sv
// Shared chess types for the move scheduler: coordinates, moves, boards, start position.
// Also holds the scheduler state encoding and the FIFO entry packing helper.
package move_exec_scheduler_pkg;

    typedef logic [5:0] coord_t;

    typedef enum logic [2:0] {
        SPECIAL_NONE,
        SPECIAL_PROMO_Q,
        SPECIAL_PROMO_R,
        SPECIAL_PROMO_B,
        SPECIAL_PROMO_N,
        SPECIAL_CASTLE,
        SPECIAL_EP,
        SPECIAL_DOUBLE
    } special_t;

    typedef struct packed {
        coord_t   from_sq;
        coord_t   to_sq;
        special_t special;
    } move_t;

    // Square index = rank*8 + file; piece codes 1..6 = P,N,B,R,Q,K, +8 for black.
    typedef struct packed {
        logic             stm;
        logic [3:0]       castle;
        logic [6:0]       ep_sq;
        logic [63:0][3:0] sq;
    } board_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } sched_state_t;

    localparam int ENTRY_W = $bits(move_t) + 1;

    localparam board_t START_BOARD = {1'b0, 4'hF, 7'h40,
        256'hCABEDBAC_99999999_00000000_00000000_00000000_00000000_11111111_42365324};

    function automatic logic [ENTRY_W-1:0] pack_entry(input move_t mv, input logic publish);
        return {mv, publish};
    endfunction

endpackage

// File: rtl/move_sched_fifo.sv
// Pending-move FIFO: synchronous, power-of-two depth, same-cycle push/pop allowed.
// Latency: pushed data visible at pop_dat the cycle after push.
// Backpressure: push ignored when full, pop ignored when empty.
module move_sched_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/move_exec_scheduler.sv
// Move scheduler: round-robin queues parse/bm moves, issues them one at a time to the executor,
// owns the current board. Latency: empty-queue enqueue at N -> exec_valid_out at N+3.
// Backpressure: requester readies drop when the FIFO is full; loads wait until idle and drained.
// Optional watchdog on executor response: define MOVE_SCHED_TIMEOUT_EN.
module move_exec_scheduler
    import move_exec_scheduler_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic   clk_in,
    input  logic   rst_in,
    input  move_t  parse_move_in,
    input  logic   parse_last_in,
    input  logic   parse_valid_in,
    output logic   parse_ready_out,
    input  move_t  bm_move_in,
    input  logic   bm_valid_in,
    output logic   bm_ready_out,
    input  board_t load_board_in,
    input  logic   load_publish_in,
    input  logic   load_valid_in,
    output logic   load_ready_out,
    output board_t exec_board_out,
    output move_t  exec_move_out,
    output logic   exec_valid_out,
    input  board_t exec_board_in,
    input  logic   exec_valid_in,
    output board_t board_out,
    output logic   board_out_valid,
    output logic   busy_out,
    output logic   timeout_out
);

    sched_state_t state, state_nxt;

    board_t cur_board;
    logic   head_pub;
    logic   prio_bm;
    logic   parse_acc;
    logic   bm_acc;
    logic   load_acc;
    logic   wait_done;

    logic                         fifo_push;
    logic [ENTRY_W-1:0]           fifo_push_dat;
    logic                         fifo_pop;
    logic [ENTRY_W-1:0]           fifo_pop_dat;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(QUEUE_DEPTH):0] fifo_count;

    // prio_bm set means bm was not served last and wins a tie.
    assign parse_ready_out = !rst_in && !fifo_full && parse_valid_in && (!bm_valid_in || !prio_bm);
    assign bm_ready_out    = !rst_in && !fifo_full && bm_valid_in && (!parse_valid_in || prio_bm);
    assign parse_acc       = parse_valid_in && parse_ready_out;
    assign bm_acc          = bm_valid_in && bm_ready_out;

    assign fifo_push     = parse_acc || bm_acc;
    assign fifo_push_dat = parse_acc ? pack_entry(parse_move_in, parse_last_in)
                                     : pack_entry(bm_move_in, 1'b1);

    assign load_ready_out = !rst_in && (state == ST_IDLE) && fifo_empty;
    assign busy_out       = (fifo_count != '0) || (state != ST_IDLE);

    move_sched_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (fifo_pop),
        .pop_dat  (fifo_pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

`ifdef MOVE_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          timeout_q;

    assign to_hit      = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_out = timeout_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt <= (state == ST_WAIT) ? to_cnt + 1'b1 : '0;
            if (state == ST_WAIT && !exec_valid_in && to_hit) timeout_q <= 1'b1;
        end
    end
`else
    // TIMEOUT_CYCLES is a positive count, so this is constant 0.
    assign timeout_out = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        load_acc  = 1'b0;
        wait_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_nxt = ST_ISSUE;
                else if (load_valid_in && load_ready_out) load_acc = 1'b1;
            end
            ST_ISSUE: begin
                fifo_pop  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (exec_valid_in) begin
                    wait_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
`ifdef MOVE_SCHED_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cur_board       <= START_BOARD;
            board_out       <= START_BOARD;
            board_out_valid <= 1'b0;
            exec_board_out  <= START_BOARD;
            exec_move_out   <= '0;
            exec_valid_out  <= 1'b0;
            head_pub        <= 1'b0;
            prio_bm         <= 1'b0;
        end else begin
            board_out_valid <= 1'b0;
            exec_valid_out  <= 1'b0;
            if (fifo_push) prio_bm <= parse_acc;
            // Executor operands are captured once and held through WAIT.
            if (fifo_pop) begin
                {exec_move_out, head_pub} <= fifo_pop_dat;
                exec_board_out            <= cur_board;
                exec_valid_out            <= 1'b1;
            end
            if (load_acc) begin
                cur_board <= load_board_in;
                if (load_publish_in) begin
                    board_out       <= load_board_in;
                    board_out_valid <= 1'b1;
                end
            end
            if (wait_done) begin
                cur_board <= exec_board_in;
                if (head_pub) begin
                    board_out       <= exec_board_in;
                    board_out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_move_exec_scheduler.sv
// Directed bench for move_exec_scheduler with a latency-programmable executor model.
module tb_move_exec_scheduler;
    import move_exec_scheduler_pkg::*;

    logic   clk_in = 1'b0;
    logic   rst_in;
    move_t  parse_move_in;
    logic   parse_last_in, parse_valid_in, parse_ready_out;
    move_t  bm_move_in;
    logic   bm_valid_in, bm_ready_out;
    board_t load_board_in;
    logic   load_publish_in, load_valid_in, load_ready_out;
    board_t exec_board_out;
    move_t  exec_move_out;
    logic   exec_valid_out;
    board_t exec_board_in;
    logic   exec_valid_in;
    board_t board_out;
    logic   board_out_valid, busy_out, timeout_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int     ex_cyc[$];
    move_t  ex_mv[$];
    board_t ex_bd[$];
    int     pub_cyc[$];
    board_t pub_bd[$];

    int     exec_lat = 1;
    logic   exec_stall = 1'b0;
    int     kick_req = 0;
    int     kick_ack = 0;
    logic   pend = 1'b0;
    int     pend_cnt = 0;
    board_t cap_bd;
    move_t  cap_mv;

    move_exec_scheduler dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .parse_move_in   (parse_move_in),
        .parse_last_in   (parse_last_in),
        .parse_valid_in  (parse_valid_in),
        .parse_ready_out (parse_ready_out),
        .bm_move_in      (bm_move_in),
        .bm_valid_in     (bm_valid_in),
        .bm_ready_out    (bm_ready_out),
        .load_board_in   (load_board_in),
        .load_publish_in (load_publish_in),
        .load_valid_in   (load_valid_in),
        .load_ready_out  (load_ready_out),
        .exec_board_out  (exec_board_out),
        .exec_move_out   (exec_move_out),
        .exec_valid_out  (exec_valid_out),
        .exec_board_in   (exec_board_in),
        .exec_valid_in   (exec_valid_in),
        .board_out       (board_out),
        .board_out_valid (board_out_valid),
        .busy_out        (busy_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic move_t mk(input int f, input int t);
        move_t m;
        m.from_sq = coord_t'(f);
        m.to_sq   = coord_t'(t);
        m.special = SPECIAL_NONE;
        return m;
    endfunction

    function automatic board_t apply_mv(input board_t b, input move_t m);
        board_t r = b;
        r.sq[m.to_sq]   = b.sq[m.from_sq];
        r.sq[m.from_sq] = 4'h0;
        r.stm           = ~b.stm;
        return r;
    endfunction

    // Monitor plus executor model, evaluated mid-cycle.
    always @(negedge clk_in) begin
        cyc = cyc + 1;
        if (exec_valid_out) begin
            ex_cyc.push_back(cyc);
            ex_mv.push_back(exec_move_out);
            ex_bd.push_back(exec_board_out);
        end
        if (board_out_valid) begin
            pub_cyc.push_back(cyc);
            pub_bd.push_back(board_out);
        end
        exec_valid_in = 1'b0;
        if (kick_req != kick_ack) begin
            kick_ack      = kick_req;
            exec_valid_in = 1'b1;
            exec_board_in = apply_mv(cap_bd, cap_mv);
            pend          = 1'b0;
        end else if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                exec_valid_in = 1'b1;
                exec_board_in = apply_mv(cap_bd, cap_mv);
                pend          = 1'b0;
            end
        end
        if (exec_valid_out) begin
            cap_bd = exec_board_out;
            cap_mv = exec_move_out;
            if (!exec_stall) begin
                pend     = 1'b1;
                pend_cnt = exec_lat;
            end
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy_out; i++) tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        parse_valid_in = 1'b1; parse_last_in = 1'b0; parse_move_in = mk(12, 28);
        bm_valid_in = 1'b0; bm_move_in = mk(0, 0);
        load_valid_in = 1'b0; load_publish_in = 1'b0; load_board_in = START_BOARD;
        tick(); tick(); tick();
        checks++; if (exec_valid_out !== 1'b0) begin errors++; $display("FAIL rst_exec_valid got=%b exp=0", exec_valid_out); end
        checks++; if (board_out_valid !== 1'b0) begin errors++; $display("FAIL rst_board_valid got=%b exp=0", board_out_valid); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_out); end
        checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%b exp=0", timeout_out); end
        checks++; if (parse_ready_out !== 1'b0) begin errors++; $display("FAIL rst_parse_ready got=%b exp=0", parse_ready_out); end
        checks++; if (load_ready_out !== 1'b0) begin errors++; $display("FAIL rst_load_ready got=%b exp=0", load_ready_out); end
        checks++; if (board_out !== START_BOARD) begin errors++; $display("FAIL rst_board got=%h exp=%h", board_out, START_BOARD); end
        parse_valid_in = 1'b0;
        rst_in = 1'b0;
        tick();
        checks++; if (load_ready_out !== 1'b1) begin errors++; $display("FAIL idle_load_ready got=%b exp=1", load_ready_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy_out); end
    endtask

    task automatic test_parse_pair();
        int b0, p0, n;
        move_t m1, m2;
        board_t b1, b2;
        m1 = mk(12, 28); m2 = mk(52, 36);
        b1 = apply_mv(START_BOARD, m1);
        b2 = apply_mv(b1, m2);
        exec_stall = 1'b0; exec_lat = 5;
        b0 = ex_cyc.size(); p0 = pub_cyc.size();
        tick();
        parse_move_in = m1; parse_last_in = 1'b0; parse_valid_in = 1'b1;
        #1;
        checks++; if (parse_ready_out !== 1'b1) begin errors++; $display("FAIL pair_ready1 got=%b exp=1", parse_ready_out); end
        n = cyc;
        tick();
        parse_move_in = m2; parse_last_in = 1'b1;
        #1;
        checks++; if (parse_ready_out !== 1'b1) begin errors++; $display("FAIL pair_ready2 got=%b exp=1", parse_ready_out); end
        tick();
        parse_valid_in = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        checks++;
        if (ex_cyc.size() - b0 !== 2) begin
            errors++; $display("FAIL pair_exec_count got=%0d exp=2", ex_cyc.size() - b0);
        end else begin
            checks++; if (ex_cyc[b0] !== n + 3) begin errors++; $display("FAIL pair_exec1_cycle got=%0d exp=%0d", ex_cyc[b0], n + 3); end
            checks++; if (ex_mv[b0] !== m1) begin errors++; $display("FAIL pair_exec1_move got=%h exp=%h", ex_mv[b0], m1); end
            checks++; if (ex_bd[b0] !== START_BOARD) begin errors++; $display("FAIL pair_exec1_board got=%h exp=%h", ex_bd[b0], START_BOARD); end
            checks++; if (ex_cyc[b0+1] !== n + 11) begin errors++; $display("FAIL pair_exec2_cycle got=%0d exp=%0d", ex_cyc[b0+1], n + 11); end
            checks++; if (ex_mv[b0+1] !== m2) begin errors++; $display("FAIL pair_exec2_move got=%h exp=%h", ex_mv[b0+1], m2); end
            checks++; if (ex_bd[b0+1] !== b1) begin errors++; $display("FAIL pair_exec2_board got=%h exp=%h", ex_bd[b0+1], b1); end
        end
        checks++;
        if (pub_cyc.size() - p0 !== 1) begin
            errors++; $display("FAIL pair_pub_count got=%0d exp=1", pub_cyc.size() - p0);
        end else begin
            checks++; if (pub_cyc[p0] !== n + 17) begin errors++; $display("FAIL pair_pub_cycle got=%0d exp=%0d", pub_cyc[p0], n + 17); end
            checks++; if (pub_bd[p0] !== b2) begin errors++; $display("FAIL pair_pub_board got=%h exp=%h", pub_bd[p0], b2); end
        end
    endtask

    task automatic test_round_robin();
        int b0, p0, np, nb;
        logic exp_p;
        move_t exp_seq[6];
        do_reset();
        exec_stall = 1'b0; exec_lat = 1;
        b0 = ex_cyc.size(); p0 = pub_cyc.size();
        np = 0; nb = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            parse_move_in = mk(8 + np, 16 + np); parse_last_in = 1'b0; parse_valid_in = 1'b1;
            bm_move_in = mk(48 + nb, 40 + nb); bm_valid_in = 1'b1;
            #1;
            exp_p = (i % 2 == 0);
            checks++;
            if (parse_ready_out !== exp_p || bm_ready_out !== !exp_p) begin
                errors++; $display("FAIL rr_grant%0d got p=%b b=%b exp p=%b b=%b", i, parse_ready_out, bm_ready_out, exp_p, !exp_p);
            end
            if (parse_ready_out) np++;
            if (bm_ready_out) nb++;
        end
        tick();
        parse_valid_in = 1'b0; bm_valid_in = 1'b0;
        wait_idle();
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rr_drain busy got=%b exp=0", busy_out); end
        for (int i = 0; i < 3; i++) begin
            exp_seq[2*i]   = mk(8 + i, 16 + i);
            exp_seq[2*i+1] = mk(48 + i, 40 + i);
        end
        checks++;
        if (ex_cyc.size() - b0 !== 6) begin
            errors++; $display("FAIL rr_exec_count got=%0d exp=6", ex_cyc.size() - b0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (ex_mv[b0+i] !== exp_seq[i]) begin errors++; $display("FAIL rr_order%0d got=%h exp=%h", i, ex_mv[b0+i], exp_seq[i]); end
            end
        end
        checks++; if (pub_cyc.size() - p0 !== 3) begin errors++; $display("FAIL rr_pub_count got=%0d exp=3", pub_cyc.size() - p0); end
    endtask

    task automatic test_fill();
        int b0, acc, k, got, got_cyc;
        do_reset();
        exec_stall = 1'b1;
        b0 = ex_cyc.size();
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            parse_move_in = mk(acc, acc + 16); parse_last_in = 1'b0; parse_valid_in = 1'b1;
            #1;
            if (parse_ready_out) acc++;
        end
        checks++; if (acc !== 9) begin errors++; $display("FAIL fill_accepted got=%0d exp=9", acc); end
        tick();
        parse_move_in = mk(acc, acc + 16);
        bm_move_in = mk(63, 62); bm_valid_in = 1'b1;
        #1;
        checks++; if (parse_ready_out !== 1'b0 || bm_ready_out !== 1'b0) begin errors++; $display("FAIL full_readies got p=%b b=%b exp 0 0", parse_ready_out, bm_ready_out); end
        checks++; if (load_ready_out !== 1'b0) begin errors++; $display("FAIL full_load_ready got=%b exp=0", load_ready_out); end
        bm_valid_in = 1'b0;
        k = cyc;
        exec_stall = 1'b0; exec_lat = 1;
        kick_req++;
        got = 0; got_cyc = -1;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (got > 0) parse_valid_in = 1'b0;
            #1;
            if (parse_valid_in && parse_ready_out) begin got++; got_cyc = cyc; end
        end
        parse_valid_in = 1'b0;
        checks++; if (got !== 1) begin errors++; $display("FAIL full_refill_count got=%0d exp=1", got); end
        checks++; if (got_cyc !== k + 4) begin errors++; $display("FAIL full_refill_cycle got=%0d exp=%0d", got_cyc, k + 4); end
        wait_idle();
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL fill_drain busy got=%b exp=0", busy_out); end
        checks++;
        if (ex_cyc.size() - b0 !== 10) begin
            errors++; $display("FAIL fill_exec_count got=%0d exp=10", ex_cyc.size() - b0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (ex_mv[b0+i] !== mk(i, i + 16)) begin errors++; $display("FAIL fill_order%0d got=%h exp=%h", i, ex_mv[b0+i], mk(i, i + 16)); end
            end
        end
    endtask

    task automatic test_load();
        int b0, p0, n, lc;
        board_t cust;
        move_t m;
        cust = START_BOARD; cust.sq[12] = 4'h0; cust.stm = 1'b1;
        m = mk(6, 21);
        exec_stall = 1'b0; exec_lat = 2;
        b0 = ex_cyc.size(); p0 = pub_cyc.size();
        tick();
        load_board_in = cust; load_publish_in = 1'b0; load_valid_in = 1'b1;
        #1;
        checks++; if (load_ready_out !== 1'b1) begin errors++; $display("FAIL load_ready_idle got=%b exp=1", load_ready_out); end
        tick();
        load_valid_in = 1'b0;
        tick(); tick();
        checks++; if (pub_cyc.size() !== p0) begin errors++; $display("FAIL load_nopub got=%0d exp=%0d", pub_cyc.size(), p0); end
        tick();
        parse_move_in = m; parse_last_in = 1'b1; parse_valid_in = 1'b1;
        n = cyc;
        tick();
        parse_valid_in = 1'b0;
        load_board_in = START_BOARD; load_publish_in = 1'b1; load_valid_in = 1'b1;
        #1;
        checks++; if (load_ready_out !== 1'b0) begin errors++; $display("FAIL load_ready_queued got=%b exp=0", load_ready_out); end
        lc = -1;
        for (int i = 0; i < 40; i++) begin
            if (load_ready_out) begin lc = cyc; break; end
            tick();
        end
        tick();
        load_valid_in = 1'b0;
        tick(); tick();
        checks++; if (lc !== n + 6) begin errors++; $display("FAIL load_accept_cycle got=%0d exp=%0d", lc, n + 6); end
        checks++; if (ex_bd.size() > b0 && ex_bd[b0] !== cust) begin errors++; $display("FAIL load_exec_board got=%h exp=%h", ex_bd[b0], cust); end
        checks++;
        if (pub_cyc.size() - p0 !== 2) begin
            errors++; $display("FAIL load_pub_count got=%0d exp=2", pub_cyc.size() - p0);
        end else begin
            checks++; if (pub_bd[p0] !== apply_mv(cust, m)) begin errors++; $display("FAIL load_pub_move got=%h exp=%h", pub_bd[p0], apply_mv(cust, m)); end
            checks++; if (pub_bd[p0+1] !== START_BOARD || pub_cyc[p0+1] !== n + 7) begin errors++; $display("FAIL load_pub_start got=%h @%0d exp=%h @%0d", pub_bd[p0+1], pub_cyc[p0+1], START_BOARD, n + 7); end
        end
    endtask

    task automatic test_reset_wait();
        int b0, p0;
        exec_stall = 1'b1;
        b0 = ex_cyc.size(); p0 = pub_cyc.size();
        tick();
        parse_move_in = mk(12, 28); parse_last_in = 1'b1; parse_valid_in = 1'b1;
        tick();
        parse_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL rw_busy_wait got=%b exp=1", busy_out); end
`ifndef MOVE_SCHED_TIMEOUT_EN
        for (int i = 0; i < 70; i++) tick();
        checks++; if (timeout_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL rw_no_watchdog got to=%b busy=%b exp 0 1", timeout_out, busy_out); end
`endif
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        kick_req++;
        tick(); tick(); tick();
        checks++; if (pub_cyc.size() !== p0) begin errors++; $display("FAIL rw_no_publish got=%0d exp=%0d", pub_cyc.size(), p0); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rw_busy got=%b exp=0", busy_out); end
        checks++; if (board_out !== START_BOARD) begin errors++; $display("FAIL rw_board_out got=%h exp=%h", board_out, START_BOARD); end
        exec_stall = 1'b0; exec_lat = 1;
        tick();
        parse_move_in = mk(1, 18); parse_last_in = 1'b0; parse_valid_in = 1'b1;
        tick();
        parse_valid_in = 1'b0;
        wait_idle();
        checks++;
        if (ex_bd.size() - b0 !== 2) begin
            errors++; $display("FAIL rw_exec_count got=%0d exp=2", ex_bd.size() - b0);
        end else if (ex_bd[b0+1] !== START_BOARD) begin
            errors++; $display("FAIL rw_cur_board got=%h exp=%h", ex_bd[b0+1], START_BOARD);
        end
    endtask

`ifdef MOVE_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int b0, p0, t;
        move_t m2;
        m2 = mk(11, 27);
        do_reset();
        exec_stall = 1'b1;
        b0 = ex_cyc.size(); p0 = pub_cyc.size();
        tick();
        parse_move_in = mk(12, 28); parse_last_in = 1'b1; parse_valid_in = 1'b1;
        tick();
        parse_move_in = m2;
        tick();
        parse_valid_in = 1'b0;
        tick(); tick();
        t = (ex_cyc.size() > b0) ? ex_cyc[b0] : cyc;
        while (cyc < t + 63) tick();
        checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", timeout_out); end
        exec_stall = 1'b0; exec_lat = 1;
        tick();
        checks++; if (timeout_out !== 1'b1) begin errors++; $display("FAIL to_rise got=%b exp=1", timeout_out); end
        wait_idle();
        checks++; if (ex_cyc.size() - b0 !== 2 || ex_cyc[b0+1] !== t + 66) begin errors++; $display("FAIL to_next_issue got n=%0d exp n=2 at %0d", ex_cyc.size() - b0, t + 66); end
        checks++; if (pub_cyc.size() - p0 !== 1 || pub_bd[p0] !== apply_mv(START_BOARD, m2)) begin errors++; $display("FAIL to_publish got n=%0d exp 1 with dropped move skipped", pub_cyc.size() - p0); end
        checks++; if (timeout_out !== 1'b1) begin errors++; $display("FAIL to_sticky got=%b exp=1", timeout_out); end
        do_reset();
        tick();
        checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL to_clear got=%b exp=0", timeout_out); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_parse_pair();
        test_round_robin();
        test_fill();
        test_load();
        test_reset_wait();
`ifdef MOVE_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_exec_scheduler.md
Name: move_exec_scheduler

Overview:
- Owns the single move_executor instance and the authoritative current board.
- Queues moves from two requesters and feeds them to the executor one at a time:
  - parse: moves from the UCI "position ... moves" / "move" stream.
  - bm: best-move commits from the search output path.
- Publishes the resulting board to the search engine.
- Removes the one-move-at-a-time timing restriction from the UCI front end.

Parameters:
- QUEUE_DEPTH, 8, pending-move FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64, watchdog limit on executor response; used only with MOVE_SCHED_TIMEOUT_EN.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- parse_move_in  input  move_t  move from the UCI parser
- parse_last_in  input  1  publish the board after this move executes
- parse_valid_in  input  1  parse request valid
- parse_ready_out  output  1  parse request accepted when valid&&ready
- bm_move_in  input  move_t  best-move commit
- bm_valid_in  input  1  bm request valid
- bm_ready_out  output  1  bm request accepted when valid&&ready
- load_board_in  input  board_t  replacement board (e.g. startpos)
- load_publish_in  input  1  publish the board immediately after load
- load_valid_in  input  1  load request valid
- load_ready_out  output  1  high only when IDLE and FIFO empty
- exec_board_out  output  board_t  board driven to the executor
- exec_move_out  output  move_t  move driven to the executor
- exec_valid_out  output  1  one-cycle executor start pulse
- exec_board_in  input  board_t  executor result
- exec_valid_in  input  1  executor result valid, one cycle
- board_out  output  board_t  published board
- board_out_valid  output  1  one-cycle publish pulse
- busy_out  output  1  FIFO non-empty or state not IDLE
- timeout_out  output  1  sticky watchdog error; tied 0 without the macro

Behaviour:
- Reset values:
  - FIFO empty; state IDLE.
  - current board = START_BOARD; board_out = START_BOARD.
  - All valid/ready/busy/timeout outputs 0.
  - Round-robin pointer = parse.
- FIFO entry = {move_t, publish bit}.
  - Parse entries carry parse_last_in.
  - bm entries always carry publish = 1.
- Arbitration: one enqueue per cycle, round-robin between parse and bm.
  - parse_ready_out and bm_ready_out are combinational.
  - Ready only when the FIFO is not full and that requester is granted.
  - A lone requester is always granted.
  - When both are valid, the requester not served last wins; the pointer updates only on an accepted transfer.
- Enqueue and dequeue in the same cycle are legal: count is unchanged; full-with-simultaneous-pop still refuses the enqueue.
- FSM IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: if the FIFO is non-empty, go to ISSUE. Otherwise, on load_valid_in&&load_ready_out: current board <= load_board_in; if load_publish_in, pulse board_out_valid next cycle with board_out = the loaded board.
  - ISSUE: register the head entry. Next cycle drive exec_valid_out = 1 for exactly one cycle with exec_board_out = current board and exec_move_out = head move. Pop the FIFO, go to WAIT.
  - WAIT: hold exec_board_out/exec_move_out stable. On exec_valid_in, current board <= exec_board_in; if the entry's publish bit is set, board_out <= exec_board_in and board_out_valid = 1 on the following cycle. Then go to IDLE.
  - exec_valid_in outside WAIT is ignored.
- Latency: an empty-queue enqueue at cycle N gives exec_valid_out at N+3. Back-to-back moves have a minimum spacing of executor latency + 3 cycles.
- Loads never overtake queued moves; load_ready_out stays low until the queue drains.
- Reset mid-operation:
  - Flushes the FIFO and abandons WAIT.
  - A stale exec_valid_in arriving after reset is ignored, because state is IDLE.

Optional Feature:
- MOVE_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - On reaching TIMEOUT_CYCLES with no exec_valid_in: set timeout_out (sticky until reset), drop the entry, keep the board unchanged, go to IDLE.
  - No publish occurs for the dropped entry.
- Undefined: no counter; WAIT waits indefinitely; timeout_out = 0.

Decomposition:
- Shared chess package: move_t, board_t, coord_t, SPECIAL_* codes, START_BOARD constant.
- Sub-module move_sched_fifo: parameterised depth/width synchronous FIFO with full/empty/count and same-cycle push/pop. move_exec_scheduler instantiates it. The move_executor is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then parse e2e4 (last = 0) and e7e5 (last = 1) back-to-back; executor model latency 5 -> exactly two exec_valid_out pulses in order, one board_out_valid after the e7e5 result.
- parse and bm both valid continuously with a stub executor -> enqueues alternate parse, bm, parse, bm; neither stalls more than one cycle when the FIFO has space.
- Fill 8 entries with the executor stalled -> both readies 0; then one pop plus a simultaneous parse push -> count stays 8.
- load startpos with publish = 1 while IDLE -> board_out == START_BOARD pulse; load while the queue is non-empty -> load_ready_out = 0 until drained.
- Assert rst_in in WAIT, then the executor returns exec_valid_in 2 cycles later -> board stays START_BOARD, no publish, busy_out = 0.
- With MOVE_SCHED_TIMEOUT_EN, the executor never responds -> timeout_out rises at WAIT entry + 64 cycles, the next queued move still issues.
